// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment vector type, blank pattern and hex decode table.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    return HEX_SEG[hex];
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex-nibble to active-low 7-segment decoder, shared by display drivers.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  always_comb seg = hex_to_seg(hex);

endmodule

// File: rtl/seg_mux_n.sv
// seg_mux_n: time-multiplexed N-digit 7-segment driver with double-buffered digit data.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to suppress leading zeros (digit 0 always shown).
module seg_mux_n
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned REFRESH_DIV = 48000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output seg_t                    seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   pend_blk_q, pend_blk_d, act_blk_q, act_blk_d;
  seg_t                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic [3:0]            cur_hex;
  seg_t                  cur_seg;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  slot_last, frame_last, slot_blank;

  seg_decoder u_dec (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  // Digit selection and leading-zero mask depend only on registered state.
  always_comb begin
    cur_hex = act_dig_q[idx_q*4 +: 4];
    lz_mask = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      logic hi_zero;
      hi_zero = 1'b1;
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
        hi_zero    = hi_zero & (act_dig_q[4*i +: 4] == 4'h0);
        lz_mask[i] = hi_zero;
      end
    end
`endif
  end

  always_comb begin
    slot_last  = (cnt_q == CNT_LAST);
    frame_last = slot_last && (idx_q == IDX_LAST);

    cnt_d = slot_last ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    pend_dig_d = load ? digits : pend_dig_q;
    pend_blk_d = load ? blank  : pend_blk_q;
    // Active takes the pre-edge pending, so a load on the boundary lands one frame later.
    act_dig_d  = frame_last ? pend_dig_q : act_dig_q;
    act_blk_d  = frame_last ? pend_blk_q : act_blk_q;

    slot_blank = act_blk_q[idx_q] | lz_mask[idx_q];
    seg_d      = slot_blank ? SEG_OFF : cur_seg;
    an_d       = '1;
    if (!slot_blank && (cnt_q >= CNT_DEAD)) an_d[idx_q] = 1'b0;
    fd_d       = frame_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_blk_q <= '0;
      act_dig_q  <= '0;
      act_blk_q  <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_blk_q <= pend_blk_d;
      act_dig_q  <= act_dig_d;
      act_blk_q  <= act_blk_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
